// File: rtl/screen_pkg.sv
// Shared types and constants for the screen sequencer.
package screen_pkg;

  typedef enum logic [1:0] {
    START   = 2'd0,
    CAPTURE = 2'd1,
    THRESH  = 2'd2,
    DISPLAY = 2'd3
  } screen_t;

  localparam int H_ACTIVE_DEF = 1024;
  localparam int V_ACTIVE_DEF = 768;

  localparam int PIX_W = 12;
  localparam logic [PIX_W-1:0] RGB_BLACK = 12'h000;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for the debounced button level.
module btn_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_p1;

  // Remember last cycle's level; reset to low so a button held through reset reads as a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_p1 <= 1'b0;
    end else begin
      level_p1 <= level;
    end
  end

  assign rise = level & ~level_p1;

endmodule

// File: rtl/screen_sequencer.sv
// Frame-synchronous screen sequencer: moves between START, CAPTURE, THRESH and
// DISPLAY only at the top-left pixel of a frame and selects the matching pixel source.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int H_ACTIVE       = H_ACTIVE_DEF,
  parameter int V_ACTIVE       = V_ACTIVE_DEF,
  parameter int HOLD_FRAMES    = 4,
  parameter int TIMEOUT_FRAMES = 600
) (
  input  logic             clk_in,
  input  logic             rst_in_n,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             btnc_in,
  input  logic             sw_state_in,
  input  logic             thresh_done_in,
  input  logic [PIX_W-1:0] start_pixel_in,
  input  logic [PIX_W-1:0] cam_pixel_in,
  input  logic [PIX_W-1:0] thresh_pixel_in,
  input  logic [PIX_W-1:0] disp_pixel_in,
  output logic [PIX_W-1:0] pixel_out,
  output logic [1:0]       state_out,
  output logic             state_change_out,
  output logic             freeze_out
);

  localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_FRAMES);
  localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [10:0]      H_LIM    = 11'(H_ACTIVE);
  localparam logic [9:0]       V_LIM    = 10'(V_ACTIVE);

  // Frame counter advance that parks at the timeout value instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt >= CNT_MAX) ? cnt : cnt + CNT_ONE;
  endfunction

  screen_t          state_q;
  screen_t          next_state;
  logic             req_q;
  logic [CNT_W-1:0] frames_q;
  logic             state_change_q;
  logic             freeze_q;
  logic             rise;
  logic             tick;
  logic             eff_req;
  logic             hold_ok;
  logic             active;
  logic [PIX_W-1:0] src_pix;
  logic [PIX_W-1:0] pix_p1;

  btn_edge_detect u_btn_edge (
    .clk   (clk_in),
    .rst_n (rst_in_n),
    .level (btnc_in),
    .rise  (rise)
  );

  assign tick    = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign eff_req = req_q | rise;
  assign hold_ok = frames_q >= CNT_HOLD;
  assign active  = (hcount_in < H_LIM) && (vcount_in < V_LIM);

  // Next-screen decision; only a frame tick may move the state
  always_comb begin
    next_state = state_q;
    if (tick) begin
      case (state_q)
        START:   if (eff_req && hold_ok && sw_state_in) next_state = CAPTURE;
        CAPTURE: if (eff_req && hold_ok)                next_state = THRESH;
        THRESH:  if (thresh_done_in)                    next_state = DISPLAY;
        DISPLAY: if ((eff_req && hold_ok) || (frames_q == CNT_TO)) next_state = START;
        default: next_state = START;
      endcase
    end
  end

  // Source select follows the next state so the tick pixel already comes from the new screen
  always_comb begin
    src_pix = RGB_BLACK;
    case (next_state)
      START:   src_pix = start_pixel_in;
      CAPTURE: src_pix = cam_pixel_in;
      THRESH:  src_pix = thresh_pixel_in;
      DISPLAY: src_pix = disp_pixel_in;
      default: src_pix = RGB_BLACK;
    endcase
  end

  // Screen state, press latch, frame counter and registered status outputs
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q        <= START;
      req_q          <= 1'b0;
      frames_q       <= '0;
      state_change_q <= 1'b0;
      freeze_q       <= 1'b0;
    end else begin
      state_q        <= next_state;
      state_change_q <= (next_state != state_q);
      freeze_q       <= (next_state == THRESH) || (next_state == DISPLAY);
      if (tick) begin
        // Presses never outlive the frame they were made in
        req_q    <= 1'b0;
        frames_q <= (next_state != state_q) ? '0 : sat_inc(frames_q);
      end else begin
        req_q    <= req_q | rise;
      end
    end
  end

  // Output pixel register: one cycle after the coordinates, black outside the active area
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      pix_p1 <= RGB_BLACK;
    end else begin
      pix_p1 <= active ? src_pix : RGB_BLACK;
    end
  end

  assign pixel_out        = pix_p1;
  assign state_out        = state_q;
  assign state_change_out = state_change_q;
  assign freeze_out       = freeze_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: short synthetic frames, a per-cycle reference model
// and directed literal checks at the interesting frame ticks.
module tb_screen_sequencer;

  localparam int HOLD    = 4;
  localparam int TIMEOUT = 600;

  logic        clk;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        btnc;
  logic        sw;
  logic        thresh_done;
  logic [11:0] start_pix, cam_pix, thresh_pix, disp_pix;
  logic [11:0] pixel_out;
  logic [1:0]  state_out;
  logic        state_change_out;
  logic        freeze_out;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] pcnt   = 8'd0;
  bit         pix_hold = 1'b0;

  // Reference model state
  int          m_state;
  int          m_frames;
  bit          m_req;
  bit          m_prev;
  bit          m_chg;
  logic [11:0] m_pix;
  int          nxt;
  bit          edge_now;
  bit          eff;
  bit          hold;

  screen_sequencer dut (
    .clk_in           (clk),
    .rst_in_n         (rst_n),
    .hcount_in        (hcount),
    .vcount_in        (vcount),
    .btnc_in          (btnc),
    .sw_state_in      (sw),
    .thresh_done_in   (thresh_done),
    .start_pixel_in   (start_pix),
    .cam_pixel_in     (cam_pix),
    .thresh_pixel_in  (thresh_pix),
    .disp_pixel_in    (disp_pix),
    .pixel_out        (pixel_out),
    .state_out        (state_out),
    .state_change_out (state_change_out),
    .freeze_out       (freeze_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pick(input int s);
    case (s)
      0:       return start_pix;
      1:       return cam_pix;
      2:       return thresh_pix;
      default: return disp_pix;
    endcase
  endfunction

  // Reference model: apply the screen rules to the sampled inputs, then compare
  always @(posedge clk) begin
    if (!rst_n) begin
      m_state  = 0;
      m_frames = 0;
      m_req    = 1'b0;
      m_prev   = 1'b0;
      m_chg    = 1'b0;
      m_pix    = 12'h000;
    end else begin
      edge_now = btnc && !m_prev;
      m_prev   = btnc;
      nxt      = m_state;
      if (hcount == 0 && vcount == 0) begin
        eff  = m_req || edge_now;
        hold = (m_frames >= HOLD);
        if (m_state == 0 && eff && hold && sw)                           nxt = 1;
        else if (m_state == 1 && eff && hold)                            nxt = 2;
        else if (m_state == 2 && thresh_done)                            nxt = 3;
        else if (m_state == 3 && ((eff && hold) || m_frames == TIMEOUT-1)) nxt = 0;
        if (nxt != m_state) m_frames = 0;
        else if (m_frames < TIMEOUT) m_frames = m_frames + 1;
        m_req = 1'b0;
      end else begin
        m_req = m_req || edge_now;
      end
      m_chg   = (nxt != m_state);
      m_pix   = (hcount < 1024 && vcount < 768) ? pick(nxt) : 12'h000;
      m_state = nxt;
    end
    #1;
    chk("model_state",  int'(state_out),        m_state);
    chk("model_change", int'(state_change_out), int'(m_chg));
    chk("model_freeze", int'(freeze_out),       (m_state >= 2) ? 1 : 0);
    chk("model_pixel",  int'(pixel_out),        int'(m_pix));
  end

  task automatic drive(input int h, input int v, input bit b);
    @(negedge clk);
    hcount = h[10:0];
    vcount = v[9:0];
    btnc   = b;
    if (!pix_hold) begin
      pcnt       = pcnt + 8'd1;
      start_pix  = {4'h1, pcnt};
      cam_pix    = {4'h2, pcnt};
      thresh_pix = {4'h3, pcnt};
      disp_pix   = {4'h4, pcnt};
    end
  endtask

  // Frame tick cycle; returns just after the edge that samples it
  task automatic tick_cycle(input bit press);
    drive(0, 0, press);
    @(posedge clk);
    #2;
  endtask

  // Remainder of a short frame, including blanking coordinates; optional press mid-frame
  task automatic rest(input bit press);
    drive(1, 0, 1'b0);
    drive(5, 3, press);
    drive(1024, 3, press);
    drive(1023, 767, 1'b0);
    drive(3, 768, 1'b0);
  endtask

  task automatic frame(input bit press_mid, input bit press_tick);
    tick_cycle(press_tick);
    rest(press_mid);
  endtask

  // Move one screen forward by a request after the hold time has elapsed
  task automatic advance();
    repeat (4) frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
  endtask

  task automatic to_display();
    advance();
    chk("to_capture", int'(state_out), 1);
    advance();
    chk("to_thresh", int'(state_out), 2);
    thresh_done = 1'b1;
    frame(1'b0, 1'b0);
    thresh_done = 1'b0;
    chk("to_display", int'(state_out), 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; hcount = 11'd7; vcount = 10'd100; btnc = 1'b0;
    sw = 1'b0; thresh_done = 1'b0;
    start_pix = 12'h100; cam_pix = 12'h200; thresh_pix = 12'h300; disp_pix = 12'h400;
    repeat (3) @(negedge clk);
    chk("reset_pixel", int'(pixel_out), 0);
    chk("reset_state", int'(state_out), 0);
    chk("reset_freeze", int'(freeze_out), 0);
    rst_n = 1'b1;

    // Switch low: press in frame 10 is discarded at the frame 11 tick
    repeat (9) frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    tick_cycle(1'b0);
    chk("sw_low_stay", int'(state_out), 0);
    chk("sw_low_nochg", int'(state_change_out), 0);
    rest(1'b0);
    sw = 1'b1;
    tick_cycle(1'b0);
    chk("req_cleared", int'(state_out), 0);
    rest(1'b1);
    tick_cycle(1'b0);
    chk("sw_high_capture", int'(state_out), 1);
    chk("capture_pulse", int'(state_change_out), 1);
    rest(1'b1);
    chk("pulse_one_cycle", int'(state_change_out), 0);

    // Hold: presses seen with 0 and 3 frames are ignored, 4 frames is honoured
    tick_cycle(1'b0);
    chk("hold_f0", int'(state_out), 1);
    rest(1'b0);
    tick_cycle(1'b0);
    rest(1'b0);
    tick_cycle(1'b0);
    rest(1'b1);
    tick_cycle(1'b0);
    chk("hold_f3", int'(state_out), 1);
    rest(1'b1);
    tick_cycle(1'b0);
    chk("hold_f4_thresh", int'(state_out), 2);
    chk("thresh_freeze", int'(freeze_out), 1);

    // THRESH ignores presses; done mid-frame only acts at the next tick
    rest(1'b1);
    tick_cycle(1'b0);
    chk("thresh_ignores_req", int'(state_out), 2);
    drive(1, 0, 1'b0);
    thresh_done = 1'b1;
    drive(5, 3, 1'b0);
    drive(1024, 3, 1'b0);
    drive(1023, 767, 1'b0);
    drive(3, 768, 1'b0);
    @(posedge clk); #2;
    chk("thresh_wait_tick", int'(state_out), 2);
    pix_hold = 1'b1;
    disp_pix = 12'hD3E;
    tick_cycle(1'b0);
    chk("display_entry", int'(state_out), 3);
    chk("display_pulse", int'(state_change_out), 1);
    chk("display_tick_pixel", int'(pixel_out), 12'hD3E);
    thresh_done = 1'b0;
    pix_hold = 1'b0;
    rest(1'b0);

    // DISPLAY early exit by a press on the tick itself
    frame(1'b0, 1'b0);
    tick_cycle(1'b1);
    chk("display_hold_f1", int'(state_out), 3);
    rest(1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    tick_cycle(1'b1);
    chk("display_press_exit", int'(state_out), 0);
    chk("display_exit_pulse", int'(state_change_out), 1);
    rest(1'b0);

    // Idle timeout: count ticks spent in DISPLAY
    to_display();
    n = 0;
    while (n < 700) begin
      tick_cycle(1'b0);
      n++;
      if (state_out == 2'd0) break;
      rest(1'b0);
    end
    chk("timeout_ticks", n, TIMEOUT);
    chk("timeout_pulse", int'(state_change_out), 1);
    rest(1'b0);

    // Timeout and press on the same tick: one transition to START
    to_display();
    repeat (TIMEOUT - 1) frame(1'b0, 1'b0);
    chk("pre_timeout", int'(state_out), 3);
    tick_cycle(1'b1);
    chk("coincide_start", int'(state_out), 0);
    chk("coincide_pulse", int'(state_change_out), 1);
    rest(1'b0);
    tick_cycle(1'b0);
    chk("coincide_single", int'(state_out), 0);
    rest(1'b0);

    // Blanking and one-cycle latency in CAPTURE
    advance();
    chk("blank_capture", int'(state_out), 1);
    pix_hold = 1'b1;
    cam_pix = 12'hB1C;
    drive(1024, 3, 1'b0);
    @(posedge clk); #2;
    chk("blank_h1024", int'(pixel_out), 0);
    drive(5, 3, 1'b0);
    @(posedge clk); #2;
    chk("active_h5", int'(pixel_out), 12'hB1C);
    drive(1023, 767, 1'b0);
    @(posedge clk); #2;
    chk("active_corner", int'(pixel_out), 12'hB1C);
    drive(1023, 768, 1'b0);
    @(posedge clk); #2;
    chk("blank_v768", int'(pixel_out), 0);
    pix_hold = 1'b0;

    // Mid-frame reset from THRESH
    advance();
    chk("pre_reset_thresh", int'(state_out), 2);
    drive(8, 100, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    hcount = 11'd9;
    #1;
    chk("async_pixel", int'(pixel_out), 0);
    chk("async_state", int'(state_out), 0);
    chk("async_freeze", int'(freeze_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rest(1'b0);
    chk("post_reset_state", int'(state_out), 0);
    pix_hold = 1'b1;
    start_pix = 12'hA01;
    tick_cycle(1'b0);
    chk("post_reset_start_pixel", int'(pixel_out), 12'hA01);
    chk("post_reset_no_chg", int'(state_change_out), 0);
    pix_hold = 1'b0;
    rest(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Frame-synchronous controller that sequences the user-visible screens (START, CAPTURE, THRESH, DISPLAY) and selects which pixel source drives the video output. It sits between the pixel generators (start screen sprites, live camera, threshold view, result view) and the video output register stage. It converts raw button presses into screen transitions that take effect only on frame boundaries, so no frame is ever torn.

## Interface
Parameters:
- H_ACTIVE, 1024, active pixels per line.
- V_ACTIVE, 768, active lines per frame.
- HOLD_FRAMES, 4, minimum whole frames in a state before a button request is honoured.
- TIMEOUT_FRAMES, 600, frames in DISPLAY before automatic return to START.

Ports:
- clk_in  input  1  pixel clock; the only clock.
- rst_in_n  input  1  reset. One clock; reset is asynchronous and active-low.
- hcount_in  input  11  current pixel column.
- vcount_in  input  10  current line.
- btnc_in  input  1  debounced button level.
- sw_state_in  input  1  enable switch; START exits only when high.
- thresh_done_in  input  1  level from the threshold stage: result is ready.
- start_pixel_in / cam_pixel_in / thresh_pixel_in / disp_pixel_in  input  12 each  source pixels, RGB444.
- pixel_out  output  12  registered selected pixel.
- state_out  output  2  current screen: 0 START, 1 CAPTURE, 2 THRESH, 3 DISPLAY.
- state_change_out  output  1  one-cycle pulse on the cycle state_out changes.
- freeze_out  output  1  high in THRESH and DISPLAY; camera frame buffer write disable.

## Operation
- Edge detect: a rising edge of btnc_in (registered previous level) sets the sticky `req` flag.
- Frame tick: hcount_in==0 && vcount_in==0. All state changes, and all req clears, happen only on a tick.
- At each tick, with eff_req = req | edge_this_cycle, `hold_ok` = frames_in_state >= HOLD_FRAMES, the next state is:
  - START: to CAPTURE if eff_req && hold_ok && sw_state_in.
  - CAPTURE: to THRESH if eff_req && hold_ok.
  - THRESH: to DISPLAY if thresh_done_in. Requests are ignored.
  - DISPLAY: to START if (eff_req && hold_ok) || frames_in_state == TIMEOUT_FRAMES-1.
- req clears on every tick, whether honoured or discarded. Presses never carry across frames.
- frames_in_state clears to 0 on a transition. Otherwise it increments on each tick and saturates at TIMEOUT_FRAMES.
- Pixel mux selects by next state: start / cam / thresh / disp pixel for states 0/1/2/3. Pixels outside H_ACTIVE×V_ACTIVE are forced to 12'h000.

## Timing
- Reset (async assert, sync-released by the system) drives these values: state START, req 0, frames_in_state 0, pixel_out 0, state_change_out 0, freeze_out 0.
- pixel_out latency is 1 cycle from hcount_in/vcount_in and the source pixels. The pixel for (0,0) on a transition frame already comes from the new state's source.
- state_out, freeze_out and state_change_out update on the clock edge that samples the tick.
- An edge on the same cycle as a tick counts for that tick.
- A press during a non-tick cycle is acted on at the next tick, at most one frame later.
- If the timeout and a request coincide in DISPLAY, the result is START; this is a single transition.
- Reset asserted mid-frame returns everything to its reset values immediately. Operation resumes at the first tick after release.

## Structure
- Package screen_pkg holds:
  - typedef enum logic [1:0] screen_t {START, CAPTURE, THRESH, DISPLAY};
  - the H_ACTIVE and V_ACTIVE defaults;
  - the RGB444 black constant.
- One sub-module, btn_edge_detect: registered rising-edge pulse generator with the same clock and reset.

## Test plan
- Reset: hold rst_in_n low mid-frame -> pixel_out 0, state_out 0, freeze_out 0. After release, START pixels appear from the next (0,0).
- Switch gating: sw_state_in low, press at frame 10 -> stays START and req is cleared at the tick. With the switch high and a press at frame 10 -> CAPTURE at the frame 11 tick, with a one-cycle state_change_out.
- Hold: enter CAPTURE, press during frame 1 -> ignored. Press during frame 5 -> THRESH at the next tick, freeze_out goes high.
- THRESH: with thresh_done_in high mid-frame, the switch to DISPLAY happens only at the next (0,0). pixel_out at (0,0) equals disp_pixel_in, one cycle later.
- Timeout: idle in DISPLAY -> START after exactly 600 ticks. A press coinciding with tick 600 -> a single transition to START.
- Blanking/latency: drive hcount_in=1024 with cam_pixel_in=12'hB1C in CAPTURE -> pixel_out 0. At hcount_in=5 -> 12'hB1C one cycle later.
